vga_timing_gen: RTL

- Upstream raster-timing stage for the VGA path. Generates the pixel coordinates (x, y) that feed the pixel/image colour stage, plus the matching sync and blank strobes for the DAC.
- Derives a pixel-rate enable from the board clock and counts 640x480@60 Hz raster timing.
- Delays sync and blank outputs by a fixed number of clk cycles to line up with the registered RGB produced downstream.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_timing_gen_sync_delay_line.sv | 56 +++++
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Shared raster-timing constants and types for the VGA path.
//            The timing generator and the downstream colour stage both
//            import this package, so they agree on coordinate width,
//            sync polarity and the 640x480@60 Hz raster geometry.
// Contents : COORD_W, default H/V active/porch/sync sizes, derived totals,
//            sync polarity constants, sync_bus_t bundle, in_window() helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Coordinate counters are 10 bits; raster totals must stay below 1024.
  localparam int COORD_W = 10;

  // Default 640x480@60 Hz geometry (pixels / lines).
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Both syncs are active low for this mode.
  localparam logic HSYNC_ACTIVE = 1'b0;
  localparam logic VSYNC_ACTIVE = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  // Bundle carried through the sync delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_bus_t;

  // Idle value of the bundle: both syncs inactive, blanked.
  localparam sync_bus_t SYNC_IDLE = '{hsync: ~HSYNC_ACTIVE, vsync: ~VSYNC_ACTIVE, blank_n: 1'b0};

  // True when c lies in [lo, lo+len-1].
  function automatic logic in_window(input coord_t c, input int lo, input int len);
    return (int'(c) >= lo) && (int'(c) < (lo + len));
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : sync_delay_line
// Purpose  : DEPTH-stage clk shift register used to align sync/blank strobes
//            with the registered RGB path. DEPTH=0 is a straight wire.
// Ports    : clk   - clock, posedge
//            rst_n - synchronous reset, active low; loads RST_VAL into every
//                    stage
//            din   - WIDTH-bit input bundle
//            dout  - bundle delayed by DEPTH clks
// Revision : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset have nothing to drive in the zero-delay build.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n};
      assign dout      = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster timing generator. Divides clk down to a pixel-rate
//            enable, counts h/v position, and produces sync/blank strobes
//            delayed SYNC_DELAY clks to line up with the registered RGB.
// Ports    : clk         - board clock, posedge
//            rst_n       - synchronous reset, active low
//            x, y        - current h/v counts (undelayed)
//            pix_en      - one-clk pulse in the cycle x/y take a new value
//            vga_clk     - pixel clock to the DAC, 50% duty
//            hsync/vsync - active-low syncs, delayed SYNC_DELAY clks
//            blank_n     - high in active area, delayed SYNC_DELAY clks
//            sync_n      - composite sync, tied low
//            video_on    - undelayed active-area flag
//            frame_start - one-clk pulse when (0,0) is presented
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pix_en,
  output logic               vga_clk,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic               sync_n,
  output logic               video_on,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

  // --------------------------------------------------------------------------
  // Divider and raster counters
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               pix_en_q, pix_en_d;
  logic               vga_clk_q, vga_clk_d;
  logic               frame_start_q, frame_start_d;
  logic               started_q, started_d;
  logic               pix_tick;
  logic               h_wrap;
  logic               v_wrap;

  always_comb begin
    pix_tick = (div_cnt_q == DIV_LAST);
    h_wrap   = (h_cnt_q == H_LAST);
    v_wrap   = (v_cnt_q == V_LAST);

    div_cnt_d = pix_tick ? '0 : div_cnt_q + 1'b1;

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    // pix_en goes high together with the counter update it marks.
    pix_en_d  = pix_tick;
    vga_clk_d = (div_cnt_q < DIV_HALF);

    // started_q stays low only during reset, so the first clk after release
    // flags the (0,0) the counters were reset to.
    started_d     = 1'b1;
    frame_start_d = !started_q || (pix_tick && h_wrap && v_wrap);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
      started_q     <= started_d;
    end
  end

  // --------------------------------------------------------------------------
  // Raw sync/blank terms from the current counters, then the delay line
  // --------------------------------------------------------------------------
  logic      video_on_w;
  sync_bus_t raw_bus;
  sync_bus_t dly_bus;

  always_comb begin
    video_on_w      = (h_cnt_q < COORD_W'(H_ACTIVE)) && (v_cnt_q < COORD_W'(V_ACTIVE));
    raw_bus.hsync   = in_window(h_cnt_q, H_ACTIVE + H_FP, H_SYNC) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    raw_bus.vsync   = in_window(v_cnt_q, V_ACTIVE + V_FP, V_SYNC) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    raw_bus.blank_n = video_on_w;
  end

  sync_delay_line #(
    .WIDTH   ($bits(sync_bus_t)),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (raw_bus),
    .dout  (dly_bus)
  );

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign pix_en      = pix_en_q;
  assign vga_clk     = vga_clk_q;
  assign frame_start = frame_start_q;
  assign video_on    = video_on_w;
  assign hsync       = dly_bus.hsync;
  assign vsync       = dly_bus.vsync;
  assign blank_n     = dly_bus.blank_n;
  assign sync_n      = 1'b0;

endmodule
`default_nettype wire
